rr_arb_2to1: RTL
================

// Module: rr_arb_2to1
// PURPOSE
//   Two-channel round-robin stream arbiter, sitting directly upstream of the 2:1 mux datapath.
//   - Accepts words from two valid/ready producers and decides which channel is selected.
//   - Drives the select (s) of the per-bit MUX_2to1 datapath.
//   - Holds the muxed word in a one-entry output register with a valid/ready handshake.
//   - Guarantees fairness: both channels requesting continuously -> strict alternation.
// PARAMETERS
//   WIDTH   8   data width of d0, d1, y
//   CNT_W   8   width of per-channel transfer counters (saturating)
// PORTS
//   clk      in   1       single clock; all state on rising edge
//   rst      in   1       reset, asynchronous, active-high
//   v0       in   1       channel 0 word valid
//   d0       in   WIDTH   channel 0 data
//   r0       out  1       channel 0 ready (transfer when v0 & r0)
//   v1       in   1       channel 1 word valid
//   d1       in   WIDTH   channel 1 data
//   r1       out  1       channel 1 ready (transfer when v1 & r1)
//   y        out  WIDTH   registered output word
//   s        out  1       registered source of y (0 = ch0, 1 = ch1)
//   y_valid  out  1       y holds an unconsumed word
//   y_ready  in   1       consumer ready (transfer when y_valid & y_ready)
//   cnt0     out  CNT_W   ch0 words accepted, saturates at all-ones
//   cnt1     out  CNT_W   ch1 words accepted, saturates at all-ones
// BEHAVIOUR
//   Reset (async, immediate): y=0, s=0, y_valid=0, cnt0=cnt1=0, last=1.
//     - last=1 means ch0 wins the first tie.
//     - r0 and r1 are 0 while rst is high.
//   State: EMPTY (y_valid=0) / FULL (y_valid=1), plus the 1-bit pointer last.
//   Load enable ld = ~y_valid | y_ready (combinational).
//     - A full register is refilled in the same cycle it drains, so no bubble.
//   Pick (combinational):
//     - only v0 -> 0; only v1 -> 1
//     - both -> ~last
//     - neither -> no grant
//   Ready:
//     - r0 = ld & v0 & (pick==0); r1 = ld & v1 & (pick==1).
//     - Never both high. Each ready depends on its own valid, so a producer must not wait on
//       ready before asserting valid.
//   On grant (rising edge): y <= mux(d0,d1,pick); s <= pick; last <= pick; y_valid <= 1;
//     the granted counter increments unless already all-ones.
//   On ld with no grant: y_valid <= 0; y, s and last hold.
//   FULL with y_ready=0: y, s, y_valid stable; r0=r1=0 (backpressure to both channels).
//   Latency: one cycle from input handshake to y_valid.
//   Throughput: one word per cycle when y_ready stays high.
//   Fairness:
//     - With v0=v1=1 continuously, grants alternate strictly.
//     - A channel waits at most one grant of the other channel.
//   The pointer updates only on an actual grant; idle cycles do not rotate priority.
//   Reset asserted mid-transfer: the in-flight word is dropped, state returns to reset values
//     asynchronously, and on the first edge after release the bench sees the reset state.
//   Inputs are sampled only when the matching ready is high; data on ungranted cycles is don't-care.
// STRUCTURE
//   - Package rr_arb_pkg: localparams SEL_CH0=1'b0, SEL_CH1=1'b1; typedef state_t {EMPTY, FULL}.
//   - Datapath sub-module: a generate loop of WIDTH instances of the existing gate-level
//     MUX_2to1 cell (i0=d0[k], i1=d1[k], s=pick), registered into y.
//   - Arbiter, pointer, counters and handshake logic live in this module.
// TESTING
//   1. rst=1 pulse mid-cycle -> y=0, s=0, y_valid=0, cnt0=cnt1=0 immediately; first tie after
//      release goes to ch0.
//   2. v0=1 only, d0=8'hA5, y_ready=1 -> r0=1, r1=0; next cycle y=8'hA5, s=0, y_valid=1, cnt0=1.
//   3. v0=v1=1, d0=8'h11, d1=8'h22, y_ready=1 for 4 cycles -> y sequence 11,22,11,22;
//      s sequence 0,1,0,1; cnt0=cnt1=2.
//   4. FULL with y=8'h11, y_ready=0 for 3 cycles, v0=v1=1 -> r0=r1=0 and y stable; on y_ready=1,
//      ch1 is granted (last=0) the same cycle.
//   5. Saturation with CNT_W=2: five ch0-only transfers -> cnt0 = 1,2,3,3,3.
//   6. Idle gap: grant ch1, then v0=v1=0 for 2 cycles (y_valid falls after drain), then v0=v1=1
//      -> ch0 granted; the pointer did not rotate during idle.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared select encodings and output-register state for the 2:1 round-robin arbiter.
package rr_arb_pkg;

  localparam logic SEL_CH0 = 1'b0;
  localparam logic SEL_CH1 = 1'b1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/MUX_2to1.sv
// Gate-level single-bit 2:1 mux cell: y = s ? i1 : i0.
module MUX_2to1 (
  input  logic i0,
  input  logic i1,
  input  logic s,
  output logic y
);

  assign y = (i0 & ~s) | (i1 & s);

endmodule

// File: rtl/rr_arb_2to1_dp.sv
// Datapath: one MUX_2to1 cell per bit, steered by the arbiter pick,
// captured into the output word register when a grant occurs.
module rr_arb_2to1_dp #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             sel,
  input  logic             load,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] mux_y;
  logic [WIDTH-1:0] y_d;
  logic [WIDTH-1:0] y_q;

  for (genvar k = 0; k < WIDTH; k++) begin : g_bit
    MUX_2to1 u_mux (
      .i0 (d0[k]),
      .i1 (d1[k]),
      .s  (sel),
      .y  (mux_y[k])
    );
  end

  always_comb begin
    y_d = y_q;
    if (load) y_d = mux_y;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) y_q <= '0;
    else     y_q <= y_d;
  end

  assign y = y_q;

endmodule

// File: rtl/rr_arb_2to1.sv
// Two-channel round-robin stream arbiter with a one-entry registered output
// and saturating per-channel transfer counters.
//
//   state | meaning
//   EMPTY | output register holds no unconsumed word
//   FULL  | y holds a word waiting for y_ready
module rr_arb_2to1
  import rr_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             v0,
  input  logic [WIDTH-1:0] d0,
  output logic             r0,
  input  logic             v1,
  input  logic [WIDTH-1:0] d1,
  output logic             r1,
  output logic [WIDTH-1:0] y,
  output logic             s,
  output logic             y_valid,
  input  logic             y_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic             s_q, s_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic             ld;
  logic             pick;
  logic             grant;

  always_comb begin
    ld   = (state_q == EMPTY) | y_ready;
    pick = SEL_CH0;
    if (v0 && v1)  pick = ~last_q;
    else if (v1)   pick = SEL_CH1;

    // Readies are forced low during reset so no producer sees a phantom transfer.
    r0    = ~rst & ld & v0 & (pick == SEL_CH0);
    r1    = ~rst & ld & v1 & (pick == SEL_CH1);
    grant = r0 | r1;

    state_d = state_q;
    last_d  = last_q;
    s_d     = s_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;

    if (grant) begin
      state_d = FULL;
      last_d  = pick;
      s_d     = pick;
      if (pick == SEL_CH0) begin
        if (cnt0_q != CNT_MAX) cnt0_d = cnt0_q + CNT_ONE;
      end else begin
        if (cnt1_q != CNT_MAX) cnt1_d = cnt1_q + CNT_ONE;
      end
    end else if (ld) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      last_q  <= SEL_CH1;
      s_q     <= SEL_CH0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      s_q     <= s_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  rr_arb_2to1_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk  (clk),
    .rst  (rst),
    .d0   (d0),
    .d1   (d1),
    .sel  (pick),
    .load (grant),
    .y    (y)
  );

  assign s       = s_q;
  assign y_valid = (state_q == FULL);
  assign cnt0    = cnt0_q;
  assign cnt1    = cnt1_q;

endmodule
